// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate formats, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

endpackage

// File: rtl/imm_expand.sv
// Immediate extraction: classifies the opcode into an immediate format and sign-extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inst. R-type and unknown opcodes yield fmt_vld=0, imm=0.
module imm_expand
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    output imm_fmt_t        fmt,
    output logic            fmt_vld,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Opcode to immediate-format classification
    always_comb begin
        fmt     = IMM_I;
        fmt_vld = 1'b1;
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt_vld = 1'b0;
        endcase
    end

    // Reassemble the scattered immediate bits for the selected format
    always_comb begin
        imm32 = '0;
        if (fmt_vld) begin
            case (fmt)
                IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
                IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                IMM_U:   imm32 = {inst[31:12], 12'b0};
                IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                default: imm32 = '0;
            endcase
        end
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/pipe_decoder.sv
// RV32 decode stage with register file, pending-write scoreboard and registered ID/EX slot.
// Latency: 1 cycle from accept to out_valid. Optional WB bypass via macro REGFILE_BYPASS_EN.
// Backpressure: in_ready drops on flush, RAW/WAW hazard, or a held slot that EX is not consuming.
module pipe_decoder
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic            wb_kill,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_link,
    output logic            out_illegal
);

    localparam int ADDR_W = $clog2(NREGS);

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] link;
        logic            illegal;
    } slot_t;

    function automatic logic idx_ok(input logic [4:0] f);
        return ({27'd0, f} < 32'(NREGS));
    endfunction

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    slot_t            slot_q;
    slot_t            slot_d;
    logic             out_vld_q;

    logic [4:0]       rs1_f, rs2_f, rd_f;
    imm_fmt_t         fmt;
    logic             fmt_vld;
    logic [XLEN-1:0]  imm;
    logic             is_r, use_rs1, use_rs2, rd_wr, illegal, hazard;
    logic             wb_ok, wb_wr, wb_clr, accept;
    logic [XLEN-1:0]  rdata1, rdata2;

    assign rs1_f = in_inst[19:15];
    assign rs2_f = in_inst[24:20];
    assign rd_f  = in_inst[11:7];

    imm_expand #(.XLEN(XLEN)) u_imm (
        .inst    (in_inst),
        .fmt     (fmt),
        .fmt_vld (fmt_vld),
        .imm     (imm)
    );

    // Operand usage and legality; unknown opcodes touch no registers
    always_comb begin
        is_r    = (in_inst[6:0] == OPC_OP);
        use_rs1 = is_r || (fmt_vld && fmt != IMM_U && fmt != IMM_J);
        use_rs2 = is_r || (fmt_vld && (fmt == IMM_S || fmt == IMM_B));
        rd_wr   = is_r || (fmt_vld && (fmt == IMM_I || fmt == IMM_U || fmt == IMM_J));
        illegal = !(is_r || fmt_vld)
               || (use_rs1 && !idx_ok(rs1_f))
               || (use_rs2 && !idx_ok(rs2_f))
               || (rd_wr   && !idx_ok(rd_f));
    end

    // Writeback qualification: out-of-range and x0 targets never write nor clear
    always_comb begin
        wb_ok    = idx_ok(wb_addr) && (wb_addr != 5'd0);
        wb_wr    = wb_en && wb_ok;
        wb_clr   = (wb_en || wb_kill) && wb_ok;
        clr_mask = '0;
        if (wb_clr) clr_mask = NREGS'(1) << wb_addr[ADDR_W-1:0];
`ifdef REGFILE_BYPASS_EN
        pend_eff = pend_q & ~clr_mask;
`else
        pend_eff = pend_q;
`endif
    end

    // RAW on used sources and WAW on a written rd
    always_comb begin
        hazard = 1'b0;
        if (use_rs1 && idx_ok(rs1_f) && pend_eff[rs1_f[ADDR_W-1:0]]) hazard = 1'b1;
        if (use_rs2 && idx_ok(rs2_f) && pend_eff[rs2_f[ADDR_W-1:0]]) hazard = 1'b1;
        if (rd_wr && idx_ok(rd_f) && rd_f != 5'd0 && pend_eff[rd_f[ADDR_W-1:0]]) hazard = 1'b1;
    end

    // Register read with x0 forced to zero and optional same-cycle WB forwarding
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (idx_ok(rs1_f) && rs1_f != 5'd0) rdata1 = regs[rs1_f[ADDR_W-1:0]];
        if (idx_ok(rs2_f) && rs2_f != 5'd0) rdata2 = regs[rs2_f[ADDR_W-1:0]];
`ifdef REGFILE_BYPASS_EN
        if (wb_wr && wb_addr == rs1_f) rdata1 = wb_data;
        if (wb_wr && wb_addr == rs2_f) rdata2 = wb_data;
`endif
    end

    assign in_ready = rstn && !flush && !hazard && (!out_vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next slot contents and scoreboard set for an accepted instruction
    always_comb begin
        slot_d.opcode  = in_inst[6:0];
        slot_d.funct3  = in_inst[14:12];
        slot_d.funct7  = in_inst[31:25];
        slot_d.rd      = rd_f;
        slot_d.rdata1  = rdata1;
        slot_d.rdata2  = rdata2;
        slot_d.imm     = imm;
        slot_d.pc      = in_pc;
        slot_d.link    = in_pc + XLEN'(4);
        slot_d.illegal = illegal;
        set_mask       = '0;
        if (accept && rd_wr && !illegal && rd_f != 5'd0) set_mask = NREGS'(1) << rd_f[ADDR_W-1:0];
    end

    // Register file write at the edge; x0 is never written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_wr) begin
            regs[wb_addr[ADDR_W-1:0]] <= wb_data;
        end
    end

    // Scoreboard: clear from WB first, then set from accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pend_q <= '0;
        else       pend_q <= (pend_q & ~clr_mask) | set_mask;
    end

    // ID/EX slot: accept replaces, otherwise flush or consume empties it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_q    <= '0;
            out_vld_q <= 1'b0;
        end else if (accept) begin
            slot_q    <= slot_d;
            out_vld_q <= 1'b1;
        end else if (flush || out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_opcode  = slot_q.opcode;
    assign out_funct3  = slot_q.funct3;
    assign out_funct7  = slot_q.funct7;
    assign out_rd      = slot_q.rd;
    assign out_rdata1  = slot_q.rdata1;
    assign out_rdata2  = slot_q.rdata2;
    assign out_imm     = slot_q.imm;
    assign out_pc      = slot_q.pc;
    assign out_link    = slot_q.link;
    assign out_illegal = slot_q.illegal;

endmodule

// File: tb/tb_pipe_decoder.sv
// Randomized and directed bench for pipe_decoder against a behavioural issue model.
// Latency: checks the 1-cycle accept-to-out_valid path every cycle.
// Backpressure: drives random out_ready/flush/writeback to exercise stalls.
`timescale 1ns/1ps
module tb_pipe_decoder;
    import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_S = 2, K_B = 3, K_U = 4, K_J = 5, K_X = 6;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, flush, wb_en, wb_kill, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, wb_data;
    logic [4:0]  wb_addr, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [31:0] out_rdata1, out_rdata2, out_imm, out_pc, out_link;

    logic        q_in_valid, q_in_ready, q_flush, q_wb_en, q_wb_kill, q_out_valid, q_out_ready, q_out_illegal;
    logic [31:0] q_in_inst, q_in_pc, q_wb_data;
    logic [4:0]  q_wb_addr, q_out_rd;
    logic [6:0]  q_out_opcode, q_out_funct7;
    logic [2:0]  q_out_funct3;
    logic [31:0] q_out_rdata1, q_out_rdata2, q_out_imm, q_out_pc, q_out_link;

    pipe_decoder #(.XLEN(32), .NREGS(32)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_kill(wb_kill), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd), .out_rdata1(out_rdata1),
        .out_rdata2(out_rdata2), .out_imm(out_imm), .out_pc(out_pc), .out_link(out_link),
        .out_illegal(out_illegal)
    );

    pipe_decoder #(.XLEN(32), .NREGS(16)) u_dut16 (
        .clk(clk), .rstn(rstn), .in_valid(q_in_valid), .in_ready(q_in_ready), .in_inst(q_in_inst),
        .in_pc(q_in_pc), .flush(q_flush), .wb_en(q_wb_en), .wb_kill(q_wb_kill), .wb_addr(q_wb_addr),
        .wb_data(q_wb_data), .out_valid(q_out_valid), .out_ready(q_out_ready), .out_opcode(q_out_opcode),
        .out_funct3(q_out_funct3), .out_funct7(q_out_funct7), .out_rd(q_out_rd), .out_rdata1(q_out_rdata1),
        .out_rdata2(q_out_rdata2), .out_imm(q_out_imm), .out_pc(q_out_pc), .out_link(q_out_link),
        .out_illegal(q_out_illegal)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_vld;
    logic [31:0] e_inst, e_r1, e_r2, e_imm, e_pc;
    bit          e_ill;

    // Currently presented instruction, described by its generator
    int          g_kind;
    logic [4:0]  g_rd, g_rs1, g_rs2;
    logic [31:0] g_imm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] enc(input int k, input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7, input int imm);
        logic [31:0] u;
        u = imm;
        case (k)
            K_I:     return {u[11:0], rs1, f3, rd, opc};
            K_S:     return {u[11:5], rs2, rs1, f3, u[4:0], opc};
            K_B:     return {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], opc};
            K_U:     return {u[31:12], rd, opc};
            K_J:     return {u[20], u[10:1], u[11], u[19:12], rd, opc};
            default: return {f7, rs2, rs1, f3, rd, opc};
        endcase
    endfunction

    function automatic bit uses1(input int k); return k == K_R || k == K_I || k == K_S || k == K_B; endfunction
    function automatic bit uses2(input int k); return k == K_R || k == K_S || k == K_B; endfunction
    function automatic bit writes(input int k); return k == K_R || k == K_I || k == K_U || k == K_J; endfunction

    // Pending as seen by the hazard check this cycle
    function automatic bit pend_now(input logic [4:0] r);
        return m_pend[r] && !(BYP && (wb_en || wb_kill) && wb_addr != 5'd0 && wb_addr == r);
    endfunction

    function automatic logic [31:0] read_now(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (BYP && wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic present(input int k, input logic [6:0] opc, input int rd, input int rs1, input int rs2,
                           input int imm, input logic [2:0] f3, input logic [6:0] f7);
        g_kind  = k;
        in_inst = enc(k, opc, 5'(rd), 5'(rs1), 5'(rs2), f3, f7, imm);
        g_rd    = in_inst[11:7];
        g_rs1   = in_inst[19:15];
        g_rs2   = in_inst[24:20];
        g_imm   = (k == K_R || k == K_X) ? 32'd0 : imm;
        in_pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    endtask

    task automatic gen_rand();
        int k, rmax, imm;
        logic [6:0] opc;
        k    = $urandom_range(0, 6);
        rmax = ($urandom_range(0, 9) == 0) ? 31 : 7;
        imm  = 0;
        opc  = OPC_OP;
        case (k)
            K_R: opc = OPC_OP;
            K_I: case ($urandom_range(0, 2)) 0: opc = OPC_OP_IMM; 1: opc = OPC_LOAD; default: opc = OPC_JALR; endcase
            K_S: opc = OPC_STORE;
            K_B: opc = OPC_BRANCH;
            K_U: opc = ($urandom_range(0, 1) == 0) ? OPC_LUI : OPC_AUIPC;
            K_J: opc = OPC_JAL;
            default: case ($urandom_range(0, 2)) 0: opc = 7'b0001011; 1: opc = 7'b1111111; default: opc = 7'b0001111; endcase
        endcase
        case (k)
            K_I, K_S: imm = int'($urandom_range(0, 4095)) - 2048;
            K_B:      imm = 2 * (int'($urandom_range(0, 4095)) - 2048);
            K_U:      imm = int'($urandom & 32'hFFFF_F000);
            K_J:      imm = 2 * (int'($urandom_range(0, 1048575)) - 524288);
            default:  imm = 0;
        endcase
        present(k, opc, $urandom_range(0, rmax), $urandom_range(0, rmax), $urandom_range(0, rmax),
                imm, 3'($urandom), 7'($urandom));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_vld = 1'b0;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; wb_kill = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
        if (m_vld) begin
            chk("out_opcode",  {25'd0, out_opcode}, {25'd0, e_inst[6:0]});
            chk("out_funct3",  {29'd0, out_funct3}, {29'd0, e_inst[14:12]});
            chk("out_funct7",  {25'd0, out_funct7}, {25'd0, e_inst[31:25]});
            chk("out_rd",      {27'd0, out_rd},     {27'd0, e_inst[11:7]});
            chk("out_rdata1",  out_rdata1, e_r1);
            chk("out_rdata2",  out_rdata2, e_r2);
            chk("out_imm",     out_imm,    e_imm);
            chk("out_pc",      out_pc,     e_pc);
            chk("out_link",    out_link,   e_pc + 32'd4);
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, e_ill});
        end
    endtask

    // One clock of the model: called at posedge+1 with inputs set, returns at next posedge+1
    task automatic cycle(output bit acc);
        bit hz, rdy;
        logic [31:0] r1v, r2v;
        #1;
        hz = 0;
        if (uses1(g_kind) && pend_now(g_rs1)) hz = 1;
        if (uses2(g_kind) && pend_now(g_rs2)) hz = 1;
        if (writes(g_kind) && g_rd != 5'd0 && pend_now(g_rd)) hz = 1;
        rdy = !flush && !hz && (!m_vld || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        acc = in_valid && rdy;
        r1v = read_now(g_rs1);
        r2v = read_now(g_rs2);
        if ((wb_en || wb_kill) && wb_addr != 5'd0) m_pend[wb_addr] = 1'b0;
        if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        if (acc) begin
            if (writes(g_kind) && g_rd != 5'd0) m_pend[g_rd] = 1'b1;
            m_vld = 1; e_inst = in_inst; e_r1 = r1v; e_r2 = r2v; e_imm = g_imm; e_pc = in_pc;
            e_ill = (g_kind == K_X);
        end else if (flush || out_ready) begin
            m_vld = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_opcode"},    {25'd0, out_opcode}, 32'd0);
        chk({tag, "_rd"},        {27'd0, out_rd},    32'd0);
        chk({tag, "_rdata1"},    out_rdata1, 32'd0);
        chk({tag, "_imm"},       out_imm,    32'd0);
        chk({tag, "_link"},      out_link,   32'd0);
        chk({tag, "_illegal"},   {31'd0, out_illegal}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        rstn = 1'b0;
        idle();
        in_inst = 0; in_pc = 0; g_kind = K_X; g_rd = 0; g_rs1 = 0; g_rs2 = 0; g_imm = 0;
        q_in_valid = 0; q_flush = 0; q_wb_en = 0; q_wb_kill = 0; q_wb_addr = 0; q_wb_data = 0;
        q_out_ready = 1; q_in_inst = 0; q_in_pc = 32'h100;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // RV32E instance: out-of-range rd is illegal and out-of-range WB is dropped
        q_in_inst = enc(K_R, OPC_OP, 5'd20, 5'd1, 5'd2, 3'd0, 7'd0, 0);
        q_in_valid = 1;
        #1 chk("e16_in_ready", {31'd0, q_in_ready}, 32'd1);
        @(posedge clk); #1;
        q_in_valid = 0;
        chk("e16_valid",   {31'd0, q_out_valid},   32'd1);
        chk("e16_illegal", {31'd0, q_out_illegal}, 32'd1);
        chk("e16_rd",      {27'd0, q_out_rd},      32'd20);
        q_wb_en = 1; q_wb_addr = 5'd20; q_wb_data = 32'h1234_5678;
        @(posedge clk); #1;
        q_wb_en = 0;
        q_in_inst = enc(K_R, OPC_OP, 5'd5, 5'd4, 5'd0, 3'd0, 7'd0, 0);
        q_in_valid = 1;
        #1 chk("e16_noalias_rdy", {31'd0, q_in_ready}, 32'd1);
        @(posedge clk); #1;
        q_in_valid = 0;
        chk("e16_noalias_x4", q_out_rdata1, 32'd0);
        chk("e16_legal",      {31'd0, q_out_illegal}, 32'd0);

        // addi x1,x0,5
        present(K_I, OPC_OP_IMM, 1, 0, 0, 5, 3'd0, 7'd0);
        chk("addi_encoding", in_inst, 32'h0050_0093);
        in_valid = 1;
        cycle(acc);
        chk("addi_imm", out_imm, 32'd5);

        // RAW on x1, cleared by writeback after a few stalled cycles
        present(K_R, OPC_OP, 2, 1, 1, 0, 3'd0, 7'd0);
        cycle(acc);
        cycle(acc);
        chk("raw_stall", {31'd0, in_ready}, 32'd0);
        wb_en = 1; wb_addr = 5'd1; wb_data = 32'd5;
        cycle(acc);
        wb_en = 0;
        if (!acc) cycle(acc);
        in_valid = 0;
        chk("raw_rdata1", out_rdata1, 32'd5);
        chk("raw_rd", {27'd0, out_rd}, 32'd2);

        // Backpressure for 4 cycles, then back-to-back issue; also seed x3
        out_ready = 0;
        present(K_I, OPC_OP_IMM, 5, 0, 0, 1, 3'd0, 7'd0);
        in_valid = 1;
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h33;
        cycle(acc);
        wb_en = 0;
        repeat (3) cycle(acc);
        out_ready = 1;
        cycle(acc);
        present(K_I, OPC_OP_IMM, 6, 0, 0, 2, 3'd0, 7'd0);
        cycle(acc);
        chk("b2b_rd", {27'd0, out_rd}, 32'd6);

        // Flush an entry writing x3; x3 stays pending until wb_kill
        present(K_I, OPC_OP_IMM, 3, 0, 0, 9, 3'd0, 7'd0);
        cycle(acc);
        in_valid = 0; flush = 1;
        cycle(acc);
        flush = 0;
        chk("flush_vld", {31'd0, out_valid}, 32'd0);
        present(K_R, OPC_OP, 4, 3, 0, 0, 3'd0, 7'd0);
        cycle(acc);
        chk("flush_pend3", {31'd0, in_ready}, 32'd0);
        wb_kill = 1; wb_addr = 5'd3;
        cycle(acc);
        wb_kill = 0;
        in_valid = 1;
        cycle(acc);
        in_valid = 0;
        chk("kill_x3_keep", out_rdata1, 32'h33);

        // Write to x0 is ignored
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        present(K_R, OPC_OP, 7, 0, 0, 0, 3'd0, 7'd0);
        in_valid = 1;
        cycle(acc);
        wb_en = 0;
        present(K_R, OPC_OP, 8, 0, 0, 0, 3'd0, 7'd0);
        cycle(acc);
        chk("x0_reads_zero", out_rdata1, 32'd0);

        // Unknown opcode issues as illegal and sets no pending bit
        present(K_X, 7'b0001011, 9, 1, 1, 0, 3'd0, 7'd0);
        cycle(acc);
        chk("illegal_flag", {31'd0, out_illegal}, 32'd1);
        present(K_I, OPC_OP_IMM, 10, 9, 0, 1, 3'd0, 7'd0);
        cycle(acc);
        chk("after_illegal_rd", {27'd0, out_rd}, 32'd10);

        // Asynchronous reset in the middle of a stall
        out_ready = 0;
        present(K_R, OPC_OP, 11, 2, 1, 0, 3'd0, 7'd0);
        cycle(acc);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        out_ready = 1;
        cycle(acc);
        in_valid = 0;
        chk("post_rst_rdata2", out_rdata2, 32'd0);
        chk("post_rst_issue", {27'd0, out_rd}, 32'd11);

        // Randomized traffic with the bench acting as WB
        for (int c = 0; c < 3000; c++) begin
            int r;
            gen_rand();
            in_valid  = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            wb_en = 0; wb_kill = 0; wb_addr = 0; wb_data = $urandom;
            r = $urandom_range(1, 7);
            if (m_pend[r] && $urandom_range(0, 9) < 5) begin
                wb_addr = 5'(r);
                if ($urandom_range(0, 3) == 0) wb_kill = 1;
                else wb_en = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                wb_addr = 5'($urandom_range(0, 31));
                wb_en = 1;
            end
            cycle(acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
